pipeline_stage_reg: RTL and testbench
=====================================

# pipeline_stage_reg

Parametrised elastic pipeline register for inter-stage boundaries (IF/ID through MEM/WB). It carries three fields per entry: instruction word, control bundle and data bundle. It adds a valid/ready handshake, stall backpressure and flush. Whenever the stage holds no valid entry it emits a NOP bubble, with the instruction set to the NOP encoding and control set to its inactive pattern. With skid buffering compiled in, it sustains full throughput with a registered `in_ready`.

## Interface
- `IR_W`, 16: instruction-word width.
- `CTRL_W`, 12: control-bundle width (write enables, mux selects).
- `DATA_W`, 112: data-bundle width (concatenated 16-bit operands and results).
- `NOP_IR`, 16'hF000: instruction value presented during bubbles, reset and flush.
- `CTRL_IDLE`, {CTRL_W{1'b1}}: control value presented during bubbles; all-ones de-asserts the active-low write enables.
- `clk` input 1: clock. Single clock domain; all state updates on the rising edge.
- `reset` input 1: reset, synchronous, active-low. Asserted when sampled 0 at a rising edge.
- `flush` input 1: synchronous kill of all held entries and of the same-cycle input.
- `in_valid` input 1: upstream presents an entry.
- `in_ready` output 1: stage can accept; an entry is accepted when `in_valid & in_ready`.
- `in_ir` input IR_W: instruction word of the input entry.
- `in_ctrl` input CTRL_W: control bundle of the input entry.
- `in_data` input DATA_W: data bundle of the input entry.
- `out_valid` output 1: head entry valid.
- `out_ready` input 1: downstream consumes the head entry when `out_valid & out_ready`.
- `out_ir` output IR_W: head instruction word, or `NOP_IR` when `out_valid`=0.
- `out_ctrl` output CTRL_W: head control bundle, or `CTRL_IDLE` when `out_valid`=0.
- `out_data` output DATA_W: head data bundle, or 0 when `out_valid`=0.
- `occupancy` output 2: number of held entries (0..2).

## Operation
- States: EMPTY (occ 0), ONE (occ 1), TWO (occ 2; reachable only with skid enabled).
- Entry storage:
  - Head register drives the outputs.
  - Skid register holds the second entry.
  - Ordering is strictly FIFO.
- State transitions, per cycle (push = accept, pop = consume):
  - Push only: occ+1. Into the head if EMPTY, else into the skid.
  - Pop only: occ-1. The skid moves to the head if TWO.
  - Push and pop at ONE: the head is replaced by the input; stays ONE.
  - Push and pop at TWO: impossible, because `in_ready`=0 at TWO.
  - Neither: hold. Head and skid contents are unchanged (stall).
- Bubble masking: when `out_valid`=0, the outputs are forced to `NOP_IR`/`CTRL_IDLE`/0 regardless of stored contents.
- Flush:
  - Next state is EMPTY.
  - The same-cycle input is discarded even if the handshake completed.
  - A same-cycle pop still counts as consumed by downstream.
- Reset:
  - Takes priority over flush.
  - Next state is EMPTY.
  - Stored fields are cleared to `NOP_IR`/`CTRL_IDLE`/0.

## Timing
- Latency: an entry accepted at edge N appears on the outputs after edge N (visible in cycle N+1).
- Reset values of all outputs:
  - `out_valid`=0, `out_ir`=`NOP_IR`, `out_ctrl`=`CTRL_IDLE`, `out_data`=0, `occupancy`=0.
  - `in_ready`=1 in the cycle after reset is released.
- Reset held low mid-stream: everything held is dropped and there is no partial output.
- Throughput: one entry per cycle with `out_ready` held at 1, from any state.
- `out_valid` and the out fields are driven from registers only; there is no combinational path from `in_*` to `out_*`.

## Configuration
- `PIPE_STAGE_SKID_EN` defined:
  - 2-entry skid buffer.
  - `in_ready` = (occ != 2), registered, with no combinational dependence on `out_ready`.
- Undefined:
  - Single entry; state TWO is absent and `occupancy` never exceeds 1.
  - `in_ready` = !`out_valid` | `out_ready`, a combinational path from `out_ready`.
  - Head is replaced on simultaneous push/pop; full throughput is retained.

## Test plan
- Reset check: drive `reset`=0 for 2 cycles with `in_valid`=1 and `in_ir`=16'h1234 -> in every cycle after the reset edge, `out_valid`=0, `out_ir`=16'hF000, `out_ctrl`=all-ones, `out_data`=0, `occupancy`=0.
- Streaming: `out_ready`=1, inject IR 16'h0001..16'h0008 on consecutive cycles -> the same sequence appears on `out_ir` one cycle later, with no gaps and `occupancy` constant at 1.
- Backpressure (skid enabled): `out_ready`=0, push A, B, C -> `occupancy` goes 1→2, `in_ready` falls after B, C is not accepted. Then set `out_ready`=1 -> outputs A, B, C in order with C accepted once `in_ready` returns.
- Flush at TWO: hold A, B and assert `flush` with `in_valid`=1 carrying C -> next cycle `occupancy`=0, `out_ir`=16'hF000, and C is never output.
- Simultaneous push/pop at ONE: head holds A, and in one cycle A is consumed while D is accepted -> next cycle `out_ir`=D and `occupancy`=1.
- Reset mid-operation at TWO with `flush`=1 -> next cycle EMPTY with masked outputs; a push on the following cycle appears normally.

Source files
------------

// File: rtl/pipeline_stage_reg.sv
// pipeline_stage_reg: elastic pipeline register between two pipeline stages.
// Carries instruction word, control bundle and data bundle per entry, with a
// valid/ready handshake, stall backpressure and flush. While no valid entry is
// held the outputs show a NOP bubble (NOP_IR / CTRL_IDLE / 0).
//
// Optional feature macro: PIPE_STAGE_SKID_EN
//   defined   : two-entry skid buffer, registered in_ready (occ != 2)
//   undefined : single entry, in_ready = !out_valid | out_ready (combinational)
//
// Ports:
//   clk, reset (sync, active-low), flush
//   in_valid/in_ready/in_ir/in_ctrl/in_data     : upstream handshake + entry
//   out_valid/out_ready/out_ir/out_ctrl/out_data : downstream handshake + head
//   occupancy                                    : held entries (0..2)
module pipeline_stage_reg #(
    parameter int unsigned        IR_W      = 16,
    parameter int unsigned        CTRL_W    = 12,
    parameter int unsigned        DATA_W    = 112,
    parameter logic [IR_W-1:0]    NOP_IR    = 16'hF000,
    parameter logic [CTRL_W-1:0]  CTRL_IDLE = {CTRL_W{1'b1}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IR_W-1:0]   in_ir,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IR_W-1:0]   out_ir,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
`ifdef PIPE_STAGE_SKID_EN
    localparam logic [1:0] TWO   = 2'd2;
`endif

    logic [1:0]        state, state_nxt;
    logic [IR_W-1:0]   head_ir, head_ir_nxt;
    logic [CTRL_W-1:0] head_ctrl, head_ctrl_nxt;
    logic [DATA_W-1:0] head_data, head_data_nxt;
    logic              push, pop;

`ifdef PIPE_STAGE_SKID_EN
    logic [IR_W-1:0]   skid_ir, skid_ir_nxt;
    logic [CTRL_W-1:0] skid_ctrl, skid_ctrl_nxt;
    logic [DATA_W-1:0] skid_data, skid_data_nxt;
    logic              in_ready_q;

    assign in_ready = in_ready_q;
`else
    // Single entry: a slot opens in the same cycle the head is consumed.
    assign in_ready = !out_valid || out_ready;
`endif

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // Head is reloaded with the bubble pattern whenever the stage empties, so
    // the outputs come straight from registers and are masked by construction.
    assign out_valid = (state != EMPTY);
    assign out_ir    = head_ir;
    assign out_ctrl  = head_ctrl;
    assign out_data  = head_data;
    assign occupancy = state;

    // Next-state and storage update logic.
    always_comb begin
        state_nxt     = state;
        head_ir_nxt   = head_ir;
        head_ctrl_nxt = head_ctrl;
        head_data_nxt = head_data;
`ifdef PIPE_STAGE_SKID_EN
        skid_ir_nxt   = skid_ir;
        skid_ctrl_nxt = skid_ctrl;
        skid_data_nxt = skid_data;
`endif
        if (flush) begin
            // Same-cycle input is dropped even if its handshake completed.
            state_nxt     = EMPTY;
            head_ir_nxt   = NOP_IR;
            head_ctrl_nxt = CTRL_IDLE;
            head_data_nxt = '0;
`ifdef PIPE_STAGE_SKID_EN
            skid_ir_nxt   = NOP_IR;
            skid_ctrl_nxt = CTRL_IDLE;
            skid_data_nxt = '0;
`endif
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        state_nxt     = ONE;
                        head_ir_nxt   = in_ir;
                        head_ctrl_nxt = in_ctrl;
                        head_data_nxt = in_data;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head_ir_nxt   = in_ir;
                        head_ctrl_nxt = in_ctrl;
                        head_data_nxt = in_data;
                    end else if (pop) begin
                        state_nxt     = EMPTY;
                        head_ir_nxt   = NOP_IR;
                        head_ctrl_nxt = CTRL_IDLE;
                        head_data_nxt = '0;
                    end
`ifdef PIPE_STAGE_SKID_EN
                    else if (push) begin
                        state_nxt     = TWO;
                        skid_ir_nxt   = in_ir;
                        skid_ctrl_nxt = in_ctrl;
                        skid_data_nxt = in_data;
                    end
`endif
                end
`ifdef PIPE_STAGE_SKID_EN
                TWO: begin
                    // in_ready is low here, so only a pop can occur.
                    if (pop) begin
                        state_nxt     = ONE;
                        head_ir_nxt   = skid_ir;
                        head_ctrl_nxt = skid_ctrl;
                        head_data_nxt = skid_data;
                        skid_ir_nxt   = NOP_IR;
                        skid_ctrl_nxt = CTRL_IDLE;
                        skid_data_nxt = '0;
                    end
                end
`endif
                default: begin
                    state_nxt     = EMPTY;
                    head_ir_nxt   = NOP_IR;
                    head_ctrl_nxt = CTRL_IDLE;
                    head_data_nxt = '0;
                end
            endcase
        end
    end

    // State and storage registers; reset dominates flush.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= EMPTY;
            head_ir   <= NOP_IR;
            head_ctrl <= CTRL_IDLE;
            head_data <= '0;
`ifdef PIPE_STAGE_SKID_EN
            skid_ir    <= NOP_IR;
            skid_ctrl  <= CTRL_IDLE;
            skid_data  <= '0;
            in_ready_q <= 1'b1;
`endif
        end else begin
            state     <= state_nxt;
            head_ir   <= head_ir_nxt;
            head_ctrl <= head_ctrl_nxt;
            head_data <= head_data_nxt;
`ifdef PIPE_STAGE_SKID_EN
            skid_ir    <= skid_ir_nxt;
            skid_ctrl  <= skid_ctrl_nxt;
            skid_data  <= skid_data_nxt;
            in_ready_q <= (state_nxt != TWO);
`endif
        end
    end

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// tb_pipeline_stage_reg: directed self-checking bench for pipeline_stage_reg.
// Skid-specific sequences are included when PIPE_STAGE_SKID_EN is defined.
module tb_pipeline_stage_reg;

    localparam int unsigned IR_W   = 16;
    localparam int unsigned CTRL_W = 12;
    localparam int unsigned DATA_W = 112;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [IR_W-1:0]   in_ir;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [IR_W-1:0]   out_ir;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;

    int n_checks = 0;
    int n_fail   = 0;

    pipeline_stage_reg dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ir     (in_ir),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ir    (out_ir),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are driven and outputs sampled here.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] ir);
        in_valid = v;
        in_ir    = ir;
        in_ctrl  = 12'(ir) ^ 12'h5A5;
        in_data  = 112'(ir) << 8;
    endtask

    task automatic expect_bubble(input string tag);
        check({tag, ".valid"}, 128'(out_valid), 128'(1'b0));
        check({tag, ".ir"},    128'(out_ir),    128'(16'hF000));
        check({tag, ".ctrl"},  128'(out_ctrl),  128'(12'hFFF));
        check({tag, ".data"},  128'(out_data),  128'(0));
        check({tag, ".occ"},   128'(occupancy), 128'(2'd0));
    endtask

    task automatic expect_head(input string tag, input logic [15:0] ir, input logic [1:0] occ);
        check({tag, ".valid"}, 128'(out_valid), 128'(1'b1));
        check({tag, ".ir"},    128'(out_ir),    128'(ir));
        check({tag, ".ctrl"},  128'(out_ctrl),  128'(12'(ir) ^ 12'h5A5));
        check({tag, ".data"},  128'(out_data),  128'(112'(ir) << 8));
        check({tag, ".occ"},   128'(occupancy), 128'(occ));
    endtask

    initial begin
        reset     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b1, 16'h1234);

        // Reset held two cycles with a live input.
        cycle();
        expect_bubble("rst0");
        cycle();
        expect_bubble("rst1");

        reset = 1'b1;
        drive(1'b0, 16'h0000);
        cycle();
        check("rdy_after_rst", 128'(in_ready), 128'(1'b1));
        expect_bubble("idle");

        // Streaming with out_ready held high.
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 16'(i));
            cycle();
            expect_head($sformatf("stream%0d", i), 16'(i), 2'd1);
        end
        drive(1'b0, 16'h0000);
        cycle();
        expect_bubble("drain");

        // Stall at ONE, then simultaneous push/pop.
        out_ready = 1'b0;
        drive(1'b1, 16'h00A0);
        cycle();
        expect_head("loadA", 16'h00A0, 2'd1);
        drive(1'b0, 16'h0000);
`ifdef PIPE_STAGE_SKID_EN
        check("rdy_stall", 128'(in_ready), 128'(1'b1));
`else
        check("rdy_stall", 128'(in_ready), 128'(1'b0));
`endif
        cycle();
        expect_head("stallA", 16'h00A0, 2'd1);
        out_ready = 1'b1;
        drive(1'b1, 16'h00D0);
        #1;
        check("rdy_pushpop", 128'(in_ready), 128'(1'b1));
        cycle();
        expect_head("pushpopD", 16'h00D0, 2'd1);

        // Flush at ONE with a live input: input discarded.
        out_ready = 1'b0;
        flush     = 1'b1;
        drive(1'b1, 16'h00E0);
        cycle();
        flush = 1'b0;
        drive(1'b0, 16'h0000);
        expect_bubble("flush1");
        cycle();
        expect_bubble("flush1_hold");

`ifdef PIPE_STAGE_SKID_EN
        // Backpressure into the skid buffer.
        drive(1'b1, 16'h000A);
        cycle();
        expect_head("bpA", 16'h000A, 2'd1);
        drive(1'b1, 16'h000B);
        cycle();
        expect_head("bpB", 16'h000A, 2'd2);
        check("bp_rdy_low", 128'(in_ready), 128'(1'b0));
        drive(1'b1, 16'h000C);
        cycle();
        expect_head("bpC_refused", 16'h000A, 2'd2);
        out_ready = 1'b1;
        cycle();
        expect_head("bp_outB", 16'h000B, 2'd1);
        check("bp_rdy_back", 128'(in_ready), 128'(1'b1));
        cycle();
        expect_head("bp_outC", 16'h000C, 2'd1);
        drive(1'b0, 16'h0000);
        cycle();
        expect_bubble("bp_drain");

        // Flush at TWO with C on the input.
        out_ready = 1'b0;
        drive(1'b1, 16'h000A);
        cycle();
        drive(1'b1, 16'h000B);
        cycle();
        check("pre_flush2_occ", 128'(occupancy), 128'(2'd2));
        flush = 1'b1;
        drive(1'b1, 16'h000C);
        cycle();
        flush = 1'b0;
        drive(1'b0, 16'h0000);
        expect_bubble("flush2");
`endif

        // Reset mid-operation with flush also asserted.
        out_ready = 1'b0;
        drive(1'b1, 16'h00F0);
        cycle();
`ifdef PIPE_STAGE_SKID_EN
        drive(1'b1, 16'h00F1);
        cycle();
        check("pre_rst_occ", 128'(occupancy), 128'(2'd2));
`else
        check("pre_rst_occ", 128'(occupancy), 128'(2'd1));
`endif
        reset = 1'b0;
        flush = 1'b1;
        drive(1'b1, 16'h00F2);
        cycle();
        expect_bubble("rst_mid");
        reset = 1'b1;
        flush = 1'b0;
        drive(1'b1, 16'h0123);
        cycle();
        expect_head("post_rst_push", 16'h0123, 2'd1);
        drive(1'b0, 16'h0000);
        out_ready = 1'b1;
        cycle();
        expect_bubble("final_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
